// File: rtl/sensor_cmd_dispatch.sv
// Sensor command dispatcher: parses 2-byte UART commands, starts one
// sensor channel and streams a 3-byte status/int/frac reply.
module sensor_cmd_dispatch #(
    parameter int         N_CH        = 4,
    parameter logic [7:0] MAX_REQ     = 8'h07,
    parameter int         TIMEOUT_CYC = 50_000_000,
    parameter int         GAP_CYC     = 5_000_000
) (
    input  logic              i_Clock,
    input  logic              i_Reset,
    input  logic              i_Rx_DV,
    input  logic [7:0]        i_Rx_Byte,
    output logic [7:0]        o_request,
    output logic [N_CH-1:0]   o_ch_en,
    input  logic [N_CH-1:0]   i_ch_done,
    input  logic [N_CH-1:0]   i_ch_err,
    input  logic [8*N_CH-1:0] i_ch_data_int,
    input  logic [8*N_CH-1:0] i_ch_data_frac,
    output logic              o_Tx_Start,
    output logic [7:0]        o_Tx_Byte,
    input  logic              i_Tx_Done,
    output logic              o_busy
);

    localparam int MAXP = (TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC;
    localparam int CW   = $clog2(MAXP) + 1;
    localparam int AW   = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_ADDR,
        S_CHECK,
        S_START,
        S_WAIT,
        S_LOAD,
        S_SEND,
        S_WAIT_TX
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    code_q, code_d;
    logic [7:0]    addr_q, addr_d;
    logic [7:0]    stat_q, stat_d;
    logic [7:0]    int_q, int_d;
    logic [7:0]    frac_q, frac_d;
    logic [1:0]    idx_q, idx_d;
    logic [CW-1:0] gap_q, gap_d;
    logic [CW-1:0] to_q, to_d;

    logic [AW-1:0] ch;
    logic          sel_done;
    logic          sel_err;
    logic [7:0]    sel_int;
    logic [7:0]    sel_frac;
    logic [7:0]    tx_byte;

    assign ch = addr_q[AW-1:0];

    // Only the addressed channel is visible to the FSM.
    always_comb begin
        sel_done = 1'b0;
        sel_err  = 1'b0;
        sel_int  = 8'h00;
        sel_frac = 8'h00;
        for (int k = 0; k < N_CH; k++) begin
            if (ch == AW'(k)) begin
                sel_done = i_ch_done[k];
                sel_err  = i_ch_err[k];
                sel_int  = i_ch_data_int[8*k +: 8];
                sel_frac = i_ch_data_frac[8*k +: 8];
            end
        end
    end

    always_comb begin
        unique case (idx_q)
            2'd0:    tx_byte = stat_q;
            2'd1:    tx_byte = int_q;
            default: tx_byte = frac_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        addr_d  = addr_q;
        stat_d  = stat_q;
        int_d   = int_q;
        frac_d  = frac_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        to_d    = to_q;
        unique case (state_q)
            S_IDLE: begin
                if (i_Rx_DV) begin
                    code_d  = i_Rx_Byte;
                    gap_d   = '0;
                    state_d = S_GET_ADDR;
                end
            end
            S_GET_ADDR: begin
                if (i_Rx_DV) begin
                    addr_d  = i_Rx_Byte;
                    state_d = S_CHECK;
                end else if (gap_q == CW'(GAP_CYC - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + CW'(1);
                end
            end
            S_CHECK: begin
                int_d  = 8'h00;
                frac_d = 8'h00;
                if (code_q > MAX_REQ) begin
                    stat_d  = 8'hFE;
                    state_d = S_LOAD;
                end else if (addr_q >= 8'(N_CH)) begin
                    stat_d  = 8'hFD;
                    state_d = S_LOAD;
                end else begin
                    state_d = S_START;
                end
            end
            S_START: begin
                to_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Done is tested first so it beats a same-cycle timeout.
                if (sel_done) begin
                    state_d = S_LOAD;
                    if (sel_err) begin
                        stat_d = 8'h1F;
                        int_d  = 8'h00;
                        frac_d = 8'h00;
                    end else begin
                        stat_d = {1'b1, code_q[6:0]};
                        int_d  = sel_int;
                        frac_d = sel_frac;
                    end
                end else if (to_q == CW'(TIMEOUT_CYC - 1)) begin
                    stat_d  = 8'hFC;
                    int_d   = 8'h00;
                    frac_d  = 8'h00;
                    state_d = S_LOAD;
                end else begin
                    to_d = to_q + CW'(1);
                end
            end
            S_LOAD: begin
                idx_d   = 2'd0;
                state_d = S_SEND;
            end
            S_SEND: begin
                state_d = S_WAIT_TX;
            end
            S_WAIT_TX: begin
                if (i_Tx_Done) begin
                    if (idx_q == 2'd2) begin
                        state_d = S_IDLE;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = S_SEND;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q <= S_IDLE;
            code_q  <= 8'h00;
            addr_q  <= 8'h00;
            stat_q  <= 8'h00;
            int_q   <= 8'h00;
            frac_q  <= 8'h00;
            idx_q   <= 2'd0;
            gap_q   <= '0;
            to_q    <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            addr_q  <= addr_d;
            stat_q  <= stat_d;
            int_q   <= int_d;
            frac_q  <= frac_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            to_q    <= to_d;
        end
    end

    assign o_request  = (state_q == S_START || state_q == S_WAIT) ?
                        code_q : 8'h00;
    assign o_ch_en    = (state_q == S_START) ? (N_CH'(1) << ch) : '0;
    assign o_Tx_Start = (state_q == S_SEND);
    assign o_Tx_Byte  = (state_q == S_SEND || state_q == S_WAIT_TX) ?
                        tx_byte : 8'h00;
    assign o_busy     = (state_q != S_IDLE && state_q != S_GET_ADDR);

endmodule

// File: tb/tb_sensor_cmd_dispatch.sv
// Scoreboard bench for sensor_cmd_dispatch: directed commands push
// expected ch_en/Tx bytes; a negedge monitor pops and compares.
module tb_sensor_cmd_dispatch;

    localparam int N_CH = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              rx_dv;
    logic [7:0]        rx_byte;
    logic [7:0]        o_request;
    logic [N_CH-1:0]   o_ch_en;
    logic [N_CH-1:0]   ch_done;
    logic [N_CH-1:0]   ch_err;
    logic [8*N_CH-1:0] ch_int;
    logic [8*N_CH-1:0] ch_frac;
    logic              o_Tx_Start;
    logic [7:0]        o_Tx_Byte;
    logic              tx_done;
    logic              o_busy;

    logic [7:0]      tx_q[$];
    logic [N_CH-1:0] en_q[$];
    int nvec  = 0;
    int nfail = 0;

    localparam logic [8*N_CH-1:0] BG_INT  = 32'hEEEE_EEEE;
    localparam logic [8*N_CH-1:0] BG_FRAC = 32'hDDDD_DDDD;

    sensor_cmd_dispatch #(
        .N_CH(N_CH),
        .MAX_REQ(8'h07),
        .TIMEOUT_CYC(100),
        .GAP_CYC(50)
    ) dut (
        .i_Clock(clk),
        .i_Reset(rst),
        .i_Rx_DV(rx_dv),
        .i_Rx_Byte(rx_byte),
        .o_request(o_request),
        .o_ch_en(o_ch_en),
        .i_ch_done(ch_done),
        .i_ch_err(ch_err),
        .i_ch_data_int(ch_int),
        .i_ch_data_frac(ch_frac),
        .o_Tx_Start(o_Tx_Start),
        .o_Tx_Byte(o_Tx_Byte),
        .i_Tx_Done(tx_done),
        .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (o_ch_en !== '0) begin
            if (en_q.size() == 0) check("unexpected_ch_en", o_ch_en, 0);
            else check("ch_en", o_ch_en, en_q.pop_front());
        end
        if (o_Tx_Start === 1'b1) begin
            if (tx_q.size() == 0) check("unexpected_tx_start", o_Tx_Start, 0);
            else check("tx_byte", o_Tx_Byte, tx_q.pop_front());
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Transmitter model: acknowledges each byte 3 cycles into WAIT_TX.
    initial begin
        logic [7:0] held;
        tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (o_Tx_Start === 1'b1) begin
                held = o_Tx_Byte;
                cyc();
                repeat (2) cyc();
                tx_done = 1'b1;
                @(negedge clk);
                if (o_busy === 1'b1) check("tx_hold", o_Tx_Byte, held);
                cyc();
                tx_done = 1'b0;
            end
        end
    end

    task automatic send(input logic [7:0] b);
        rx_dv   = 1'b1;
        rx_byte = b;
        cyc();
        rx_dv   = 1'b0;
        rx_byte = 8'h00;
    endtask

    task automatic push3(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c);
        tx_q.push_back(a);
        tx_q.push_back(b);
        tx_q.push_back(c);
    endtask

    // Returns at the negedge of the START cycle.
    task automatic cmd_en(input logic [7:0] code, input logic [7:0] addr,
                          input logic [N_CH-1:0] en, input int gap);
        int n;
        en_q.push_back(en);
        send(code);
        repeat (gap) cyc();
        send(addr);
        n = 0;
        while (o_ch_en === '0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("start_latency", n, 2);
        check("request", o_request, code);
    endtask

    task automatic pulse(input int ch, input logic err,
                         input logic [7:0] vi, input logic [7:0] vf);
        ch_done[ch]       = 1'b1;
        ch_err[ch]        = err;
        ch_int[8*ch +: 8]  = vi;
        ch_frac[8*ch +: 8] = vf;
        cyc();
        ch_done = '0;
        ch_err  = '0;
        ch_int  = BG_INT;
        ch_frac = BG_FRAC;
    endtask

    task automatic done_at(input int j, input int ch, input logic err,
                           input logic [7:0] vi, input logic [7:0] vf);
        cyc();
        repeat (j - 1) cyc();
        pulse(ch, err, vi, vf);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((tx_q.size() != 0 || o_busy !== 1'b0) && n < 3000) begin
            cyc();
            n++;
        end
        if (n >= 3000) check("idle_timeout", o_busy, 0);
    endtask

    task automatic wait_txq(input int sz);
        int n;
        n = 0;
        while (tx_q.size() > sz && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) check("txq_timeout", tx_q.size(), sz);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_request"}, o_request, 0);
        check({tag, "_ch_en"}, o_ch_en, 0);
        check({tag, "_tx_start"}, o_Tx_Start, 0);
        check({tag, "_tx_byte"}, o_Tx_Byte, 0);
        check({tag, "_busy"}, o_busy, 0);
    endtask

    initial begin
        int n;
        rst     = 1'b1;
        rx_dv   = 1'b0;
        rx_byte = 8'h00;
        ch_done = '0;
        ch_err  = '0;
        ch_int  = BG_INT;
        ch_frac = BG_FRAC;
        repeat (3) cyc();
        @(negedge clk);
        check_zero("reset");
        cyc();
        rst = 1'b0;
        cyc();

        push3(8'h81, 8'h19, 8'h05);
        cmd_en(8'h01, 8'h02, 4'b0100, 0);
        done_at(3, 2, 1'b0, 8'h19, 8'h05);
        wait_idle();

        push3(8'hFE, 8'h00, 8'h00);
        send(8'h09);
        @(negedge clk);
        check("get_addr_busy", o_busy, 0);
        send(8'h00);
        wait_idle();
        push3(8'hFD, 8'h00, 8'h00);
        send(8'h01);
        send(8'h07);
        wait_idle();

        push3(8'hFC, 8'h00, 8'h00);
        cmd_en(8'h02, 8'h01, 4'b0010, 0);
        n = 0;
        while (o_request !== 8'h00 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("wait_len", n, 101);
        wait_idle();
        push3(8'h82, 8'h33, 8'h44);
        cmd_en(8'h02, 8'h01, 4'b0010, 0);
        done_at(100, 1, 1'b0, 8'h33, 8'h44);
        wait_idle();

        push3(8'h1F, 8'h00, 8'h00);
        cmd_en(8'h01, 8'h03, 4'b1000, 0);
        cyc();
        cyc();
        pulse(0, 1'b0, 8'h55, 8'h66);
        cyc();
        pulse(3, 1'b1, 8'h77, 8'h88);
        wait_idle();

        push3(8'h83, 8'h5A, 8'hA5);
        cmd_en(8'h03, 8'h02, 4'b0100, 49);
        done_at(1, 2, 1'b0, 8'h5A, 8'hA5);
        wait_idle();

        send(8'h01);
        repeat (50) cyc();
        push3(8'h81, 8'h12, 8'h34);
        cmd_en(8'h01, 8'h00, 4'b0001, 0);
        cyc();
        send(8'h05);
        pulse(0, 1'b0, 8'h12, 8'h34);
        wait_txq(2);
        cyc();
        send(8'h03);
        wait_idle();
        repeat (5) cyc();

        tx_q.push_back(8'h81);
        cmd_en(8'h01, 8'h00, 4'b0001, 0);
        done_at(2, 0, 1'b0, 8'h11, 8'h22);
        wait_txq(0);
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        check_zero("midreset");
        repeat (20) cyc();
        push3(8'h81, 8'h44, 8'h55);
        cmd_en(8'h01, 8'h01, 4'b0010, 0);
        done_at(1, 1, 1'b0, 8'h44, 8'h55);
        wait_idle();

        repeat (5) cyc();
        check("en_q_drained", en_q.size(), 0);
        check("tx_q_drained", tx_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

    initial begin
        #200_000;
        nfail++;
        $display("FAIL watchdog: got no finish expected finish");
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $fatal(1, "watchdog expired");
    end

endmodule
